// File: rtl/wb_write_ctrl_if.sv
// Bus bundle for the writeback controller: main-pipeline slot, multi-cycle
// result handshake, buffer status and the registered register-file port.
interface wb_write_ctrl_if;
    logic        pipe_valid;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic        pipe_is_load;
    logic [31:0] alu_result;
    logic [31:0] load_raw;
    logic [2:0]  load_funct3;
    logic [1:0]  addr_low;
    logic        mc_valid;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic        stall_pipe;
    logic        pend_valid;
    logic [4:0]  pend_rd;
    logic        W_en;
    logic [4:0]  Rd;
    logic [31:0] Wr_data;

    modport slave (
        input  pipe_valid, pipe_we, pipe_rd, pipe_is_load, alu_result,
        input  load_raw, load_funct3, addr_low, mc_valid, mc_rd, mc_data,
        output mc_ready, stall_pipe, pend_valid, pend_rd, W_en, Rd, Wr_data
    );

    modport master (
        output pipe_valid, pipe_we, pipe_rd, pipe_is_load, alu_result,
        output load_raw, load_funct3, addr_low, mc_valid, mc_rd, mc_data,
        input  mc_ready, stall_pipe, pend_valid, pend_rd, W_en, Rd, Wr_data
    );
endinterface

// File: rtl/wb_write_ctrl.sv
// Writeback port arbiter: main pipeline vs. a one-entry multi-cycle result
// buffer, with starvation forcing, WAW discard and RV32I load extraction.
module wb_write_ctrl #(
    parameter int STARVE_LIMIT = 4
) (
    input logic           clk,
    input logic           rst,
    wb_write_ctrl_if.slave bus
);
    // state    | meaning
    // ST_EMPTY | buffer free, mc_ready asserted
    // ST_HELD  | buffer occupied, pipeline writes take priority
    // ST_FORCE | buffer starved, pipeline stalled while buffer drains
    typedef enum logic [1:0] {ST_EMPTY, ST_HELD, ST_FORCE} state_t;

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [4:0]    r_pend_rd;
    logic [31:0]   r_pend_data;
    logic          r_w_en;
    logic [4:0]    r_rd;
    logic [31:0]   r_wr_data;

    logic          w_capture;
    logic          w_sel_valid;
    logic [4:0]    w_sel_rd;
    logic [31:0]   w_sel_data;
    logic [31:0]   w_load_data;
    logic [31:0]   w_pipe_data;
    logic          w_pipe_wr;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;

    always_comb begin
        w_byte      = bus.load_raw[{bus.addr_low, 3'b000} +: 8];
        w_half      = bus.load_raw[{bus.addr_low[1], 4'b0000} +: 16];
        w_load_data = 32'h0;
        case (bus.load_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b010:  w_load_data = bus.load_raw;
            3'b100:  w_load_data = {24'h0, w_byte};
            3'b101:  w_load_data = {16'h0, w_half};
            default: w_load_data = 32'h0;
        endcase
    end

    assign w_pipe_data = bus.pipe_is_load ? w_load_data : bus.alu_result;
    assign w_pipe_wr   = bus.pipe_valid & bus.pipe_we;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_sel_valid = 1'b0;
        w_sel_rd    = bus.pipe_rd;
        w_sel_data  = w_pipe_data;
        case (r_state)
            ST_EMPTY: begin
                w_sel_valid = w_pipe_wr;
                if (bus.mc_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                end
            end
            ST_HELD: begin
                if (w_pipe_wr) begin
                    w_sel_valid = 1'b1;
                    // Younger pipeline write to the same rd makes the buffer stale.
                    if (bus.pipe_rd == r_pend_rd) begin
                        w_state_nxt = ST_EMPTY;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                        if (r_cnt == CW'(STARVE_LIMIT - 1)) begin
                            w_state_nxt = ST_FORCE;
                        end
                    end
                end else begin
                    w_sel_valid = 1'b1;
                    w_sel_rd    = r_pend_rd;
                    w_sel_data  = r_pend_data;
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FORCE: begin
                w_sel_valid = 1'b1;
                w_sel_rd    = r_pend_rd;
                w_sel_data  = r_pend_data;
                w_state_nxt = ST_EMPTY;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_cnt       <= '0;
            r_pend_rd   <= 5'd0;
            r_pend_data <= 32'h0;
            r_w_en      <= 1'b0;
            r_rd        <= 5'd0;
            r_wr_data   <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_capture) begin
                r_pend_rd   <= bus.mc_rd;
                r_pend_data <= bus.mc_data;
            end
            // x0 writes still consume the slot/buffer but never reach the port.
            r_w_en <= w_sel_valid && (w_sel_rd != 5'd0);
            if (w_sel_valid && (w_sel_rd != 5'd0)) begin
                r_rd      <= w_sel_rd;
                r_wr_data <= w_sel_data;
            end
        end
    end

    // Reset is synchronous, so status outputs are masked while rst is high.
    assign bus.mc_ready   = rst | (r_state == ST_EMPTY);
    assign bus.stall_pipe = ~rst & (r_state == ST_FORCE);
    assign bus.pend_valid = ~rst & (r_state != ST_EMPTY);
    assign bus.pend_rd    = r_pend_rd;
    assign bus.W_en       = r_w_en;
    assign bus.Rd         = r_rd;
    assign bus.Wr_data    = r_wr_data;
endmodule
